// File: rtl/tcm_ctrl.sv
// Tightly-coupled memory controller: req/gnt in, valid/ready response FIFO out.
// Define TCM_MEM_CLR_EN to sweep INIT_VALUE through memory after reset.
module sram #(
   parameter int NUM_WMASKS = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int DELAY      = 0
) (
   input  logic                  clk0,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   input  logic                  clk1,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1
);
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] q0;

   always_ff @(posedge clk0) begin
      if (!csb0) begin
         if (!web0) begin
            for (int i = 0; i < NUM_WMASKS; i++)
               if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
         end else begin
            q0 <= mem[addr0];
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (!csb1) dout1 <= mem[addr1];
   end

   if (DELAY == 0) begin : g_nodly
      assign dout0 = q0;
   end else begin : g_dly
      always_ff @(posedge clk0) dout0 <= q0;
   end
endmodule

module tcm_ctrl #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    MEM_WORDS  = 2 ** ADDR_WIDTH,
   parameter int                    RSP_DEPTH  = 2,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    rerr_o,
   output logic                    init_done_o
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_WORDS - 1);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t                  state;
   logic                    done_q;
   logic                    sweep;
   logic [ADDR_WIDTH-1:0]   sweep_addr;

`ifdef TCM_MEM_CLR_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= S_CLEAR;
         sweep_addr <= '0;
         done_q     <= 1'b0;
      end else if (state == S_CLEAR) begin
         if (sweep_addr == LAST) begin
            state  <= S_RUN;
            done_q <= 1'b1;
         end else begin
            sweep_addr <= sweep_addr + 1'b1;
         end
      end
   end
   assign sweep = (state == S_CLEAR);
`else
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= S_RUN;
         done_q <= 1'b1;
      end else begin
         state  <= S_RUN;
         done_q <= 1'b1;
      end
   end
   assign sweep      = 1'b0;
   assign sweep_addr = '0;
`endif

   assign init_done_o = done_q;

   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] f_data [RSP_DEPTH];
   logic [RSP_DEPTH-1:0]  f_err;
   logic                  in_range, pop, rd_acc, wr_acc;
   logic [DATA_WIDTH-1:0] sram_dout, unused_dout1;

   assign in_range = {1'b0, addr_i} < (ADDR_WIDTH + 1)'(MEM_WORDS);
   assign rvalid_o = (cnt != '0);
   assign pop      = rvalid_o & rready_i;
   // A pop on the same edge frees the slot, so a full FIFO can still grant.
   assign gnt_o    = (state == S_RUN) & req_i
                   & (we_i | (cnt < CW'(RSP_DEPTH)) | pop);
   assign rd_acc   = gnt_o & ~we_i;
   assign wr_acc   = gnt_o & we_i;
   assign rdata_o  = rvalid_o ? f_data[rd_ptr] : '0;
   assign rerr_o   = rvalid_o & f_err[rd_ptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (rd_acc)
            wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         unique case ({rd_acc, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Macro reads on the falling edge, so dout is ready for this rising edge.
   always_ff @(posedge clk_i) begin
      if (rd_acc) begin
         f_data[wr_ptr] <= in_range ? sram_dout : '0;
         f_err[wr_ptr]  <= ~in_range;
      end
   end

   sram #(
      .NUM_WMASKS (NB),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAM_DEPTH  (MEM_WORDS),
      .DELAY      (0)
   ) u_sram (
      .clk0   (~clk_i),
      .csb0   (~(sweep | ((rd_acc | wr_acc) & in_range))),
      .web0   (~(sweep | we_i)),
      .wmask0 (sweep ? {NB{1'b1}} : be_i),
      .addr0  (sweep ? sweep_addr : addr_i),
      .din0   (sweep ? INIT_VALUE : wdata_i),
      .dout0  (sram_dout),
      .clk1   (~clk_i),
      .csb1   (1'b1),
      .addr1  ('0),
      .dout1  (unused_dout1)
   );
endmodule

// File: tb/tb_tcm_ctrl.sv
// Randomized and directed checks of tcm_ctrl against a queue/array model.
// Honors TCM_MEM_CLR_EN to expect the post-reset clear sweep.
module tb_tcm_ctrl;
   localparam int DW = 32;
   localparam int AW = 12;
   localparam int MW = 3000;
   localparam int DEPTH = 2;

   logic clk = 1'b0, rst_n = 1'b0;
   logic req = 0, we = 0, rready = 0;
   logic [3:0] be = 0;
   logic [AW-1:0] addr = 0;
   logic [DW-1:0] wdata = 0;
   logic gnt, rvalid, rerr, init_done;
   logic [DW-1:0] rdata;

   tcm_ctrl #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .MEM_WORDS (MW),
      .RSP_DEPTH (DEPTH), .INIT_VALUE ('0)
   ) dut (
      .clk_i (clk), .rst_ni (rst_n), .req_i (req), .gnt_o (gnt),
      .we_i (we), .be_i (be), .addr_i (addr), .wdata_i (wdata),
      .rvalid_o (rvalid), .rready_i (rready), .rdata_o (rdata),
      .rerr_o (rerr), .init_done_o (init_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
      bit            k;
   } rsp_t;

   rsp_t          q[$];
   logic [DW-1:0] mm[int];
   int            n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_write(input int a, input logic [3:0] b,
                              input logic [DW-1:0] d);
      if (a >= MW) return;
      if (mm.exists(a)) begin
         for (int i = 0; i < 4; i++)
            if (b[i]) mm[a][i*8 +: 8] = d[i*8 +: 8];
      end else if (b == 4'hF) begin
         mm[a] = d;
      end
   endtask

   task automatic model_read(input int a);
      rsp_t r;
      if (a >= MW) begin
         r.d = '0; r.e = 1'b1; r.k = 1'b1;
      end else begin
         r.e = 1'b0;
         r.k = mm.exists(a);
         r.d = r.k ? mm[a] : '0;
      end
      q.push_back(r);
   endtask

   // Called at posedge+1; checks at posedge+4, returns at next posedge+1.
   task automatic step(input logic r, input logic w, input logic [3:0] b,
                       input int a, input logic [DW-1:0] d,
                       input logic rr, output logic g);
      logic eg;
      req = r; we = w; be = b; addr = AW'(a); wdata = d; rready = rr;
      #3;
      eg = r & (w | (q.size() < DEPTH) | ((q.size() > 0) & rr));
      chk("gnt", gnt, eg);
      chk("rvalid", rvalid, q.size() > 0);
      if (q.size() > 0) begin
         chk("rerr", rerr, q[0].e);
         if (q[0].k) chk("rdata", rdata, q[0].d);
         if (rr) void'(q.pop_front());
      end
      if (eg) begin
         if (w) model_write(a, b, d);
         else model_read(a);
      end
      g = eg;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      logic g;
      int n = 0;
      while (q.size() > 0 && n < 20) begin
         step(0, 0, 0, 0, 0, 1, g);
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   task automatic init_wait();
      int n = 0;
`ifdef TCM_MEM_CLR_EN
      chk("init_low", init_done, 0);
`endif
      req = 1; we = 0; addr = 0; rready = 1;
      while (init_done !== 1'b1 && n < 5000) begin
         #3;
         if (n < 3) begin
            chk("clr_gnt", gnt, 0);
            chk("clr_rvalid", rvalid, 0);
         end
         @(posedge clk); #1;
         n++;
      end
      req = 0;
`ifdef TCM_MEM_CLR_EN
      chk("init_cycles", n, MW);
      for (int a = 0; a < MW; a++) mm[a] = '0;
`else
      chk("init_cycles", n, 0);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic g;
      int idx;
      int bp_addr[4] = '{4, 5, 6, 7};

      repeat (3) @(posedge clk);
      #1;
      #3;
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rerr", rerr, 0);
`ifdef TCM_MEM_CLR_EN
      chk("rst_done", init_done, 0);
`else
      chk("rst_done", init_done, 1);
`endif
      @(posedge clk); #1;
      rst_n = 1;
      init_wait();

`ifdef TCM_MEM_CLR_EN
      for (int a = 0; a < 16; a++) step(1, 0, 0, a, 0, 1, g);
      drain();
`endif

      for (int a = 0; a < 16; a++)
         step(1, 1, 4'hF, a, 32'h1000_0000 + a * 32'h0101_0101, 1, g);

      step(1, 1, 4'hF, 3, 32'hA5A5A5A5, 1, g);
      step(1, 1, 4'h1, 3, 32'h000000FF, 1, g);
      step(1, 0, 0, 3, 0, 0, g);
      chk("byte_rdata", rdata, 32'hA5A5A5FF);
      chk("byte_rvalid", rvalid, 1);
      drain();

      idx = 0;
      for (int c = 0; c < 4; c++) begin
         step(1, 0, 0, bp_addr[idx], 0, 0, g);
         if (g) idx++;
      end
      chk("bp_grants", idx, 2);
      for (int c = 0; c < 10 && idx < 4; c++) begin
         step(1, 0, 0, bp_addr[idx], 0, 1, g);
         if (g) idx++;
      end
      chk("bp_all", idx, 4);
      drain();

      step(1, 0, 0, 3000, 0, 1, g);
      step(1, 1, 4'hF, 4095, 32'hDEADBEEF, 1, g);
      step(1, 0, 0, 0, 0, 1, g);
      drain();

      step(1, 0, 0, 8, 0, 0, g);
      step(1, 0, 0, 9, 0, 0, g);
      step(1, 0, 0, 10, 0, 1, g);
      step(1, 0, 0, 11, 0, 1, g);
      drain();

      for (int c = 0; c < 400; c++) begin
         int a;
         a = ($urandom % 8 == 0) ? 2998 + int'($urandom % 4)
                                 : int'($urandom % 16);
         if ($urandom % 10 == 0) a = 4095;
         step($urandom % 4 != 0, $urandom % 3 == 0, 4'($urandom),
              a, $urandom, $urandom % 3 != 0, g);
      end
      drain();

      step(1, 0, 0, 1, 0, 0, g);
      step(1, 0, 0, 2, 0, 0, g);
      #3;
      rst_n = 0;
      #1;
      chk("mid_rvalid", rvalid, 0);
      chk("mid_rdata", rdata, 0);
      q.delete();
      mm.delete();
      @(posedge clk); #1;
      rst_n = 1;
      init_wait();
      for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0, 1, g);
      step(1, 1, 4'hF, 12, 32'h0BADF00D, 1, g);
      step(1, 0, 0, 12, 0, 1, g);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
